// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   Pipelined immediate generator for the decode stage. Decodes the RV
//   I/S/B/U/J immediates and the zero-extended CSR uimm (Z) from a raw
//   instruction word, extends them to XLEN, and passes each result through a
//   valid/ready stage that has a 2-entry skid buffer, a sideband tag and a
//   synchronous flush.
//
// Ports
//   clk_i        rising-edge clock
//   rst_n_i      asynchronous active-low reset
//   flush_i      synchronous flush, drops every buffered entry
//   in_valid_i   input entry valid
//   in_ready_o   stage can take an input this cycle (registered)
//   instr_i      raw 32-bit instruction word
//   fmt_i        0=I 1=S 2=B 3=U 4=J 5=Z 6/7 reserved
//   tag_i        sideband tag carried with the immediate
//   out_valid_o  imm_o/tag_o/fmt_err_o hold a valid entry
//   out_ready_i  downstream accepts the output this cycle
//   imm_o        generated immediate
//   tag_o        tag paired with imm_o
//   fmt_err_o    entry came from a reserved fmt_i value

module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [2:0]       fmt_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             fmt_err_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;

  logic [31:0]      imm32;
  logic [XLEN-1:0]  imm_new;
  logic             err_new;

  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_err;

  logic accept;
  logic pop;

  // The opcode field never contributes to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr_i[6:0];

  // Every format is first built as a 32-bit value. For all formats except Z
  // the MSB of that value is instr[31], so a single signed widening to XLEN
  // gives the required sign extension (including U above bit 31 for XLEN=64).
  // Z has a zero MSB, so the same widening zero-extends it.
  always_comb begin
    imm32   = '0;
    err_new = 1'b0;
    case (fmt_i)
      3'd0: imm32 = 32'($signed(instr_i[31:20]));
      3'd1: imm32 = 32'($signed({instr_i[31:25], instr_i[11:7]}));
      3'd2: imm32 = 32'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                 instr_i[11:8], 1'b0}));
      3'd3: imm32 = {instr_i[31:12], 12'b0};
      3'd4: imm32 = 32'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                 instr_i[30:21], 1'b0}));
      3'd5: imm32 = {27'b0, instr_i[19:15]};
      default: begin
        imm32   = '0;
        err_new = 1'b1;
      end
    endcase
    imm_new = XLEN'($signed(imm32));
  end

  assign accept = in_valid_i & in_ready_o & ~flush_i;
  assign pop    = out_valid_o & out_ready_i;

  // Main entry is the output register set itself; skid holds the second entry.
  // in_ready_o/out_valid_o are registered copies of "not FULL"/"not EMPTY".
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= EMPTY;
      out_valid_o <= 1'b0;
      in_ready_o  <= 1'b1;
      imm_o       <= '0;
      tag_o       <= '0;
      fmt_err_o   <= 1'b0;
      skid_imm    <= '0;
      skid_tag    <= '0;
      skid_err    <= 1'b0;
    end else if (flush_i) begin
      state       <= EMPTY;
      out_valid_o <= 1'b0;
      in_ready_o  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            imm_o       <= imm_new;
            tag_o       <= tag_i;
            fmt_err_o   <= err_new;
            out_valid_o <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            imm_o     <= imm_new;
            tag_o     <= tag_i;
            fmt_err_o <= err_new;
          end else if (accept) begin
            skid_imm   <= imm_new;
            skid_tag   <= tag_i;
            skid_err   <= err_new;
            in_ready_o <= 1'b0;
            state      <= FULL;
          end else if (pop) begin
            out_valid_o <= 1'b0;
            state       <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            imm_o      <= skid_imm;
            tag_o      <= skid_tag;
            fmt_err_o  <= skid_err;
            in_ready_o <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_o <= 1'b0;
          in_ready_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe
//   Self-checking bench for imm_gen_pipe: directed vectors with literal
//   expectations, plus a queue-based reference that is compared against the
//   DUT on every cycle outside reset.

module tb_imm_gen_pipe;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [2:0]       fmt;
  logic [TAG_W-1:0] tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm;
  logic [TAG_W-1:0] tag_out;
  logic             fmt_err;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int pushes = 0;

  typedef struct {
    logic [63:0]      imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  entry_t q[$];

  imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .instr_i    (instr),
    .fmt_i      (fmt),
    .tag_i      (tag),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .imm_o      (imm),
    .tag_o      (tag_out),
    .fmt_err_o  (fmt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference immediate built with signed integer arithmetic on the fields:
  // the top field bit carries negative weight.
  function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] f,
                                          output logic err);
    longint v;
    logic [63:0] r;
    longint s;
    err = 1'b0;
    s = longint'(w[31]);
    case (f)
      3'd0: v = longint'(w[30:20]) - s * 2048;
      3'd1: v = longint'(w[30:25]) * 32 + longint'(w[11:7]) - s * 2048;
      3'd2: v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 +
                longint'(w[11:8]) * 2 - s * 4096;
      3'd3: v = longint'(w[30:12]) * 4096 - s * 64'sd2147483648;
      3'd4: v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 +
                longint'(w[30:21]) * 2 - s * 1048576;
      3'd5: v = longint'(w[19:15]);
      default: begin
        v = 0;
        err = 1'b1;
      end
    endcase
    r = 64'(v);
    if (XLEN == 32) r[63:32] = '0;
    return r;
  endfunction

  // Compare process: the queue holds what the block must contain after the
  // last rising edge. Inputs change only just after rising edges, so the
  // values seen at the falling edge are the ones the next rising edge uses.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      if (out_valid && q.size() != 0) begin
        chk("imm", 64'(imm), q[0].imm);
        chk("tag", 64'(tag_out), 64'(q[0].tag));
        chk("fmt_err", 64'(fmt_err), 64'(q[0].err));
      end
      if (flush) begin
        q.delete();
      end else begin
        if (out_valid && out_ready && q.size() != 0) begin
          void'(q.pop_front());
          pops++;
        end
        if (in_valid && in_ready) begin
          entry_t e;
          e.imm = ref_imm(instr, fmt, e.err);
          e.tag = tag;
          q.push_back(e);
          pushes++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transfer with out_ready high: accepted at the next edge, visible
  // one cycle later, drained the edge after.
  task automatic send_one(input logic [31:0] w, input logic [2:0] f,
                          input logic [TAG_W-1:0] t, input logic [63:0] exp_imm,
                          input logic exp_err, input string name);
    instr = w; fmt = f; tag = t; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_imm"}, 64'(imm), exp_imm);
    chk({name, "_tag"}, 64'(tag_out), 64'(t));
    chk({name, "_err"}, 64'(fmt_err), 64'(exp_err));
    step();
  endtask

  task automatic fill_full();
    out_ready = 1'b0;
    instr = 32'hFFF00093; fmt = 3'd0; tag = 5'd11; in_valid = 1'b1;
    step();
    tag = 5'd12;
    step();
    in_valid = 1'b0;
    chk("fill_in_ready", 64'(in_ready), 64'd0);
  endtask

  initial begin : main
    logic e;
    logic [63:0] u_exp;
    int cyc;
    bit acc;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; fmt = '0; tag = '0;

    // Pin the reference itself with a few hand-computed values.
    chk("model_I", ref_imm(32'hFFF00093, 3'd0, e), 64'h00000000FFFFFFFF);
    chk("model_B", ref_imm(32'hFE000CE3, 3'd2, e), 64'h00000000FFFFFFF8);
    chk("model_Z", ref_imm(32'h000FD073, 3'd5, e), 64'h000000000000001F);
    chk("model_rsv_err", 64'(e), 64'd0);
    void'(ref_imm(32'h12345678, 3'd7, e));
    chk("model_rsv_flag", 64'(e), 64'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_imm", 64'(imm), 64'd0);
    chk("rst_tag", 64'(tag_out), 64'd0);
    chk("rst_err", 64'(fmt_err), 64'd0);
    rst_n = 1'b1;
    step();

    // Directed formats
    u_exp = (XLEN == 64) ? 64'hFFFFFFFF80000000 : 64'h0000000080000000;
    send_one(32'hFFF00093, 3'd0, 5'd1, 64'hFFFFFFFF, 1'b0, "fmt_I");
    send_one(32'hFE512E23, 3'd1, 5'd2, 64'hFFFFFFFC, 1'b0, "fmt_S");
    send_one(32'hFE000CE3, 3'd2, 5'd3, 64'hFFFFFFF8, 1'b0, "fmt_B");
    send_one(32'h800000B7, 3'd3, 5'd4, u_exp,        1'b0, "fmt_U");
    send_one(32'h0010006F, 3'd4, 5'd5, 64'h00000800, 1'b0, "fmt_J");
    send_one(32'h000FD073, 3'd5, 5'd6, 64'h0000001F, 1'b0, "fmt_Z");
    send_one(32'hFFFFFFFF, 3'd6, 5'd7, 64'h00000000, 1'b1, "fmt_rsv6");
    send_one(32'hFFFFFFFF, 3'd7, 5'd8, 64'h00000000, 1'b1, "fmt_rsv7");

    // Backpressure: tags 1,2,3 with out_ready low
    out_ready = 1'b0;
    instr = 32'h00100093; fmt = 3'd0; in_valid = 1'b1; tag = 5'd1;
    step();
    tag = 5'd2;
    step();
    chk("bp_in_ready_full", 64'(in_ready), 64'd0);
    tag = 5'd3;
    step();
    chk("bp_in_ready_hold", 64'(in_ready), 64'd0);
    chk("bp_head_tag", 64'(tag_out), 64'd1);
    out_ready = 1'b1;
    step();
    chk("bp_second_tag", 64'(tag_out), 64'd2);
    chk("bp_in_ready_back", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp_third_tag", 64'(tag_out), 64'd3);
    chk("bp_third_valid", 64'(out_valid), 64'd1);
    step();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Flush while FULL, with an input offered in the same cycle
    fill_full();
    instr = 32'h000FD073; fmt = 3'd5; tag = 5'd9; in_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    repeat (3) step();
    chk("flush_no_output", 64'(out_valid), 64'd0);

    // Asynchronous reset between edges while FULL
    fill_full();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_imm", 64'(imm), 64'd0);
    chk("arst_tag", 64'(tag_out), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    step();
    send_one(32'hFE512E23, 3'd1, 5'd20, 64'hFFFFFFFC, 1'b0, "post_rst");

    // Random valid/ready stream of 1000 items against the queue reference
    begin
      int sent;
      int base_pops;
      sent = 0;
      base_pops = pops;
      cyc = 0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      while ((sent < 1000 || pops - base_pops < 1000) && cyc < 20000) begin
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) sent++;
        if (sent >= 1000) begin
          in_valid = 1'b0;
        end else if (acc || !in_valid) begin
          in_valid = ($urandom_range(0, 3) != 0);
          instr = $urandom;
          fmt = 3'($urandom_range(0, 7));
          tag = TAG_W'($urandom);
        end
        out_ready = (sent >= 1000) ? 1'b1 : ($urandom_range(0, 2) != 0);
      end
      chk("rand_sent", 64'(sent), 64'd1000);
      chk("rand_received", 64'(pops - base_pops), 64'd1000);
    end

    step();
    chk("end_empty", 64'(out_valid), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
